// File: rtl/msg_pkg.sv
// Shared message record and length-check helper for the parser-to-sink message queue.
package msg_pkg;

    localparam int unsigned MSG_BYTES = 32;

    typedef struct packed {
        logic [15:0]            length;
        logic [8*MSG_BYTES-1:0] data;
        logic                   error;
    } msg_t;

    function automatic logic msg_len_bad(input logic [15:0] len, input logic [15:0] max);
        return (len == 16'd0) || (len > max);
    endfunction

endpackage

// File: rtl/msg_queue.sv
// Whole-message FIFO with valid/ready output, sticky overflow and a saturating drop counter.
// Build option MSG_QUEUE_DROP_ERR_EN: errored messages are discarded silently and out_error is tied 0.
module msg_queue
    import msg_pkg::*;
#(
    parameter int unsigned MAX_MSG_BYTES = 32,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [15:0]                in_length,
    input  logic [8*MAX_MSG_BYTES-1:0] in_data,
    input  logic                       in_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_length,
    output logic [8*MAX_MSG_BYTES-1:0] out_data,
    output logic                       out_error,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_W + 1;
    localparam logic [15:0] MAX_LEN  = 16'(MAX_MSG_BYTES);

    msg_t                r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_BITS-1:0] r_count;
    logic                r_overflow;
    logic [CNT_W-1:0]    r_drop_cnt;

    msg_t w_in;
    msg_t w_head;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_in.length = in_length;
    assign w_in.data   = in_data;
    assign w_in.error  = in_error | msg_len_bad(in_length, MAX_LEN);

`ifdef MSG_QUEUE_DROP_ERR_EN
    assign w_accept = in_valid & ~w_in.error;
`else
    assign w_accept = in_valid;
`endif

    // When full, a simultaneous pop frees the head slot, which the push then reuses.
    assign w_pop  = out_valid & out_ready;
    assign w_push = w_accept & (~full | w_pop);
    assign w_drop = w_accept & full & ~w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = (r_count != '0);
    assign out_length = out_valid ? w_head.length : '0;
    assign out_data   = out_valid ? w_head.data : '0;
`ifdef MSG_QUEUE_DROP_ERR_EN
    assign out_error  = 1'b0;
`else
    assign out_error  = out_valid & w_head.error;
`endif
    assign count      = r_count;
    assign full       = (r_count == CNT_BITS'(DEPTH));
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_msg_queue.sv
// Directed self-checking bench for msg_queue (DEPTH=4), plus a CNT_W=2 instance for counter saturation.
module tb_msg_queue;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [15:0]  in_length = '0;
    logic [255:0] in_data = '0;
    logic         in_error = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_length;
    logic [255:0] out_data;
    logic         out_error;
    logic [2:0]   count;
    logic         full;
    logic         overflow;
    logic [7:0]   drop_cnt;

    logic         in2_valid = 1'b0;
    logic         out2_valid;
    logic         out2_ready = 1'b0;
    logic [15:0]  out2_length;
    logic [255:0] out2_data;
    logic         out2_error;
    logic [2:0]   count2;
    logic         full2;
    logic         overflow2;
    logic [1:0]   drop_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msg_queue #(.MAX_MSG_BYTES(32), .DEPTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_length(in_length), .in_data(in_data), .in_error(in_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_length(out_length),
        .out_data(out_data), .out_error(out_error),
        .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    msg_queue #(.MAX_MSG_BYTES(32), .DEPTH(4), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in2_valid), .in_length(16'd4), .in_data(256'h0a0b0c0d), .in_error(1'b0),
        .out_valid(out2_valid), .out_ready(out2_ready), .out_length(out2_length),
        .out_data(out2_data), .out_error(out2_error),
        .count(count2), .full(full2), .overflow(overflow2), .drop_cnt(drop_cnt2)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mkdata(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {32{b}};
    endfunction

    // One clock; also verifies the head held still across the edge when it was stalled.
    task automatic tick();
        logic         pv, pr, prst, pe;
        logic [15:0]  pl;
        logic [255:0] pd;
        pv = out_valid; pr = out_ready; prst = rst;
        pl = out_length; pd = out_data; pe = out_error;
        @(posedge clk);
        #1;
        if (prst && rst && pv && !pr) begin
            chk("stable_len", 256'(out_length), 256'(pl));
            chk("stable_data", out_data, pd);
            chk("stable_err", 256'(out_error), 256'(pe));
        end
    endtask

    task automatic push(input logic [15:0] len, input logic [255:0] data, input logic err);
        in_valid = 1'b1; in_length = len; in_data = data; in_error = err;
        tick();
        in_valid = 1'b0; in_length = '0; in_data = '0; in_error = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b1;
        tick();

        // reset state
        chk("rst_count", 256'(count), 256'(0));
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_full", 256'(full), 256'(0));
        chk("rst_overflow", 256'(overflow), 256'(0));
        chk("rst_drop", 256'(drop_cnt), 256'(0));
        chk("rst_data", out_data, 256'(0));

        // single pass, first-word-fall-through latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_length = 16'd5; in_data = 256'h0504030201; in_error = 1'b0;
        chk("pass_valid_N", 256'(out_valid), 256'(0));
        tick();
        in_valid = 1'b0; in_length = '0; in_data = '0;
        chk("pass_valid_N1", 256'(out_valid), 256'(1));
        chk("pass_len", 256'(out_length), 256'(5));
        chk("pass_data", out_data, 256'h0504030201);
        chk("pass_err", 256'(out_error), 256'(0));
        chk("pass_count1", 256'(count), 256'(1));
        tick();
        chk("pass_count0", 256'(count), 256'(0));
        chk("pass_valid_end", 256'(out_valid), 256'(0));
        chk("pass_len_empty", 256'(out_length), 256'(0));

        // reset mid-stream
        out_ready = 1'b0;
        push(16'd7, mkdata(7), 1'b0);
        push(16'd8, mkdata(8), 1'b0);
        push(16'd9, mkdata(9), 1'b0);
        chk("mid_count3", 256'(count), 256'(3));
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 256'(count), 256'(0));
        chk("mid_rst_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_drop", 256'(drop_cnt), 256'(0));
        chk("mid_rst_len", 256'(out_length), 256'(0));
        chk("mid_rst_data", out_data, 256'(0));
        chk("mid_rst_err", 256'(out_error), 256'(0));
        tick();
        rst = 1'b1;
        tick();
        chk("mid_after_count", 256'(count), 256'(0));

        // fill and overflow
        for (int k = 1; k <= 6; k++) begin
            push(16'(k), mkdata(k), 1'b0);
            if (k == 3) chk("fill_full3", 256'(full), 256'(0));
        end
        chk("ovf_full", 256'(full), 256'(1));
        chk("ovf_count", 256'(count), 256'(4));
        chk("ovf_flag", 256'(overflow), 256'(1));
        chk("ovf_drop", 256'(drop_cnt), 256'(2));
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_len", 256'(out_length), 256'(k));
            chk("drain_data", out_data, mkdata(k));
            tick();
        end
        chk("drain_count", 256'(count), 256'(0));
        chk("drain_ovf_sticky", 256'(overflow), 256'(1));

        // push and pop together while full
        out_ready = 1'b0;
        for (int k = 11; k <= 14; k++) push(16'(k), mkdata(k), 1'b0);
        chk("pp_count_before", 256'(count), 256'(4));
        out_ready = 1'b1;
        push(16'd15, mkdata(15), 1'b0);
        chk("pp_count", 256'(count), 256'(4));
        chk("pp_drop", 256'(drop_cnt), 256'(2));
        for (int k = 12; k <= 15; k++) begin
            chk("pp_order", 256'(out_length), 256'(k));
            tick();
        end
        chk("pp_empty", 256'(count), 256'(0));

        // length errors
        do_reset();
        out_ready = 1'b0;
        push(16'd0, mkdata(20), 1'b0);
        push(16'd33, mkdata(21), 1'b0);
        push(16'd32, mkdata(22), 1'b0);
        chk("len_drop", 256'(drop_cnt), 256'(0));
        chk("len_ovf", 256'(overflow), 256'(0));
`ifdef MSG_QUEUE_DROP_ERR_EN
        chk("len_count", 256'(count), 256'(1));
        chk("len_head32", 256'(out_length), 256'(32));
        chk("len_err32", 256'(out_error), 256'(0));
`else
        chk("len_count", 256'(count), 256'(3));
        out_ready = 1'b1;
        chk("len_head0", 256'(out_length), 256'(0));
        chk("len_err0", 256'(out_error), 256'(1));
        chk("len_valid0", 256'(out_valid), 256'(1));
        tick();
        chk("len_head33", 256'(out_length), 256'(33));
        chk("len_err33", 256'(out_error), 256'(1));
        tick();
        chk("len_head32", 256'(out_length), 256'(32));
        chk("len_err32", 256'(out_error), 256'(0));
        chk("len_data32", out_data, mkdata(22));
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("len_empty", 256'(count), 256'(0));

        // drop-counter saturation on the CNT_W=2 instance
        in2_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("sat_full", 256'(full2), 256'(1));
        chk("sat_drop0", 256'(drop_cnt2), 256'(0));
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("sat_drop", 256'(drop_cnt2), 256'((i < 3) ? i : 3));
        end
        in2_valid = 1'b0;
        tick();
        chk("sat_hold", 256'(drop_cnt2), 256'(3));
        chk("sat_ovf", 256'(overflow2), 256'(1));
        chk("sat_count", 256'(count2), 256'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
